alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised successor to the datapath ALU: executes one ALU command per accepted `start`, with a start/busy/done handshake, registered result and flags. Single-cycle ops (logic, add/sub, shifts, pass, BNE) complete in one cycle. Multiply is a multi-cycle shift-add sequence of WIDTH iterations. Sits between the decode/register-file read stage and writeback/PC-select in the processor datapath.

## Interface
- `WIDTH`, default 8: datapath width in bits; legal values are ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled on a rising edge when `busy`=0.
- `cmd`  in  4  operation code, sampled with `start`.
- `in_a`, `in_b`, `in_c`  in  WIDTH each  operands, sampled with `start`.
- `busy`  out  1  high while a multiply is iterating.
- `done`  out  1  one-cycle pulse when a result is registered.
- `rslt`  out  WIDTH  registered result. Held until the next completion.
- `branch_pc`  out  1  branch-taken flag. Valid only while `done`=1; 0 otherwise.
- `zero`  out  1  `rslt`==0. Updated with `rslt` and held.
- `carry`  out  1  carry/overflow flag. Updated with `rslt` and held.

## Operation
Encodings for `cmd`:
- 0000 AND: `in_b & in_a`; carry=0.
- 0001 ADD: `in_b + in_a`; carry = bit WIDTH of the (WIDTH+1)-bit sum.
- 0010 XOR: `in_b ^ in_a`; carry=0.
- 0011 BNE: if `in_b != in_a`, rslt=`in_c` and branch_pc=1. Otherwise rslt=0 and branch_pc=0. carry=0.
- 0100 LSL, 0101 LSR: `in_b` shifted by the unsigned amount `in_a`. An amount ≥ WIDTH gives 0. carry=0.
- 1001 ASR: `in_b` arithmetic right shift by `in_a`. An amount ≥ WIDTH gives all copies of the `in_b` MSB. carry=0.
- 0110 LW, 0111 STR: rslt=`in_a`; carry=0.
- 1000 SUB: `in_b - in_a`; carry=1 when no borrow, i.e. `in_b` ≥ `in_a` unsigned.
- 1010 MULLO / 1011 MULHI: unsigned product `in_b * in_a`, 2*WIDTH bits wide. MULLO returns the low half, with carry=1 if the high half is nonzero. MULHI returns the high half, with carry=0.
- Any other encoding (1100–1111) is illegal: rslt=0, carry=0, branch_pc=0; completes as a single-cycle op.
- `zero` is always recomputed from the new `rslt`.

State machine:
- States are IDLE and MUL.
- IDLE:
  - `start`=1 with a single-cycle/illegal cmd: register the result and flags, pulse `done`, stay in IDLE.
  - `start`=1 with MULLO/MULHI: latch the operands, clear the 2*WIDTH-bit accumulator and the iteration counter, go to MUL.
- MUL:
  - Each edge processes one multiplier bit of `in_b`, LSB first (add the shifted `in_a` to the accumulator if the bit is 1) and increments the counter.
  - On the WIDTH-th iteration edge: register rslt and flags, pulse `done`, return to IDLE.
  - The counter is ceil(log2(WIDTH+1)) bits.
- `start` while `busy`=1 is ignored; there is no queueing. Operand changes during MUL have no effect.

## Timing
Reset:
- While `rst_n`=0, immediately (asynchronously): state=IDLE, and busy, done, rslt, branch_pc, zero and carry are all 0.
- Reset mid-multiply aborts the operation; no `done` is produced.

Latency (`start` sampled at edge k):
- Single-cycle op: rslt, flags and `done` are valid in the cycle after edge k.
- Multiply:
  - `busy`=1 for the WIDTH cycles after edge k.
  - rslt, flags and `done` are valid in the cycle after edge k+WIDTH.
  - `busy`=0 in that `done` cycle.

Handshake:
- A new `start` is accepted in the `done` cycle, giving back-to-back issue.
- Single-cycle ops can issue every cycle; `done` then stays high continuously, one pulse per op.
- `done` and `branch_pc` are never high for more than one cycle per operation.
- Between completions, `rslt`, `zero` and `carry` hold their last values.

Arithmetic is modulo 2^WIDTH except where a carry rule is stated above.

## Test plan
- Reset then idle, WIDTH=8: all outputs 0. Deassert `rst_n`, no `start` → outputs stay 0, `busy`=0.
- ADD 0xF0+0x20 → next cycle rslt=0x10, carry=1, zero=0, `done`=1 for one cycle. Then SUB in_b=0x05, in_a=0x05 → rslt=0x00, zero=1, carry=1.
- BNE in_b=5, in_a=3, in_c=0x2A → rslt=0x2A, branch_pc=1 for one cycle. Then BNE with in_b=in_a=7 → rslt=0, branch_pc=0, zero=1.
- Shifts:
  - LSL in_b=0x81 by 1 → 0x02.
  - LSR 0x81 by 9 → 0x00.
  - ASR 0x80 by 3 → 0xF0.
  - ASR 0x80 by 12 → 0xFF.
- MULLO 0x13×0x11 (=0x0143):
  - `busy`=1 for 8 cycles, then rslt=0x43, carry=1, `done`=1.
  - A `start` with ADD during `busy` is ignored.
  - A MULHI of the same operands issued in the `done` cycle → rslt=0x01 eight cycles later.
- Reset mid-multiply: assert `rst_n`=0 at iteration 4 → all outputs 0 immediately and no `done`. A following ADD 1+1 → rslt=0x02 one cycle after `start`.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
//   Single-cycle ops (logic, add/sub, shifts, pass, BNE, illegal) complete on
//   the edge that accepts start. MULLO/MULHI run a WIDTH-step shift-add
//   sequence, one multiplier bit per edge, LSB first.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cmd[3:0]       request + opcode, sampled when busy=0
//   in_a, in_b, in_c      operands (in_c is the BNE target)
//   busy                  high while a multiply iterates
//   done                  one-cycle pulse per registered result
//   rslt, zero, carry     registered result and flags, held between completions
//   branch_pc             BNE taken, only together with done
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic             branch_pc,
  output logic             zero,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] C_AND = 4'b0000, C_ADD = 4'b0001, C_XOR = 4'b0010,
                         C_BNE = 4'b0011, C_LSL = 4'b0100, C_LSR = 4'b0101,
                         C_LW  = 4'b0110, C_STR = 4'b0111, C_SUB = 4'b1000,
                         C_ASR = 4'b1001, C_MLO = 4'b1010, C_MHI = 4'b1011;

  typedef enum logic {IDLE, MUL} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rslt_q, rslt_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic                 done_q, done_d, br_q, br_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 hi_q, hi_d;

  // Single-cycle datapath
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_rslt;
  logic             sc_carry, sc_br;

  assign add_w = {1'b0, in_b} + {1'b0, in_a};
  assign sub_w = {1'b0, in_b} - {1'b0, in_a};

  // Shift amounts >= WIDTH fall out of the language semantics: << / >> give 0,
  // >>> on a signed operand fills with the sign bit.
  always_comb begin
    sc_rslt  = '0;
    sc_carry = 1'b0;
    sc_br    = 1'b0;
    unique case (cmd)
      C_AND: sc_rslt = in_b & in_a;
      C_ADD: begin sc_rslt = add_w[WIDTH-1:0]; sc_carry = add_w[WIDTH]; end
      C_XOR: sc_rslt = in_b ^ in_a;
      C_BNE: if (in_b != in_a) begin sc_rslt = in_c; sc_br = 1'b1; end
      C_LSL: sc_rslt = in_b << in_a;
      C_LSR: sc_rslt = in_b >> in_a;
      C_ASR: sc_rslt = WIDTH'($signed(in_b) >>> in_a);
      C_LW, C_STR: sc_rslt = in_a;
      // Top bit of the widened difference is the borrow; carry means no borrow.
      C_SUB: begin sc_rslt = sub_w[WIDTH-1:0]; sc_carry = ~sub_w[WIDTH]; end
      default: ;
    endcase
  end

  // Shift-add step: multiplicand shifts left, multiplier shifts right so the
  // current bit is always mplr_q[0].
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_r;
  logic               last;

  assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mul_r    = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    rslt_d  = rslt_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    br_d    = 1'b0;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (cmd == C_MLO || cmd == C_MHI) begin
          mcand_d = {{WIDTH{1'b0}}, in_a};
          mplr_d  = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          hi_d    = cmd[0];
          state_d = MUL;
        end else begin
          rslt_d  = sc_rslt;
          carry_d = sc_carry;
          zero_d  = (sc_rslt == '0);
          br_d    = sc_br;
          done_d  = 1'b1;
        end
      end
      MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          rslt_d  = mul_r;
          carry_d = ~hi_q & (|acc_step[2*WIDTH-1:WIDTH]);
          zero_d  = (mul_r == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rslt_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      br_q    <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rslt_q  <= rslt_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  assign busy      = (state_q == MUL);
  assign done      = done_q;
  assign rslt      = rslt_q;
  assign branch_pc = br_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): table of single-cycle vectors issued
// back-to-back, then hand-written multiply, start-while-busy and reset sequences.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   cmd;
  logic [W-1:0] in_a, in_b, in_c;
  logic         busy, done, branch_pc, zero, carry;
  logic [W-1:0] rslt;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .busy(busy), .done(done), .rslt(rslt), .branch_pc(branch_pc),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a, b, c;
    logic [W-1:0] r;
    logic         cy, z, br;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".rslt"},  32'(rslt), 0);
    chk({tag, ".br"},    32'(branch_pc), 0);
    chk({tag, ".zero"},  32'(zero), 0);
    chk({tag, ".carry"}, 32'(carry), 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive a request at the negedge so it is sampled by the following posedge.
  task automatic drive(input logic s, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] cc);
    @(negedge clk);
    start = s; cmd = c; in_a = a; in_b = b; in_c = cc;
  endtask

  // MUL issued at edge k: busy for 8 cycles, then done with the given result.
  task automatic mul_run(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ec);
    drive(1'b1, c, a, b, 8'h00);
    tick();
    drive(1'b0, 4'h1, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < W - 1; j++) begin
      chk({tag, ".busy"}, 32'(busy), 1);
      tick();
    end
    chk({tag, ".busy_last"}, 32'(busy), 1);
    tick();
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy_end"}, 32'(busy), 0);
    chk({tag, ".rslt"}, 32'(rslt), 32'(er));
    chk({tag, ".carry"}, 32'(ec), 32'(carry));
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 8'h20, 8'hF0, 8'h00, 8'h10, 1, 0, 0}; // ADD carry out
    vecs[1]  = '{4'b1000, 8'h05, 8'h05, 8'h00, 8'h00, 1, 1, 0}; // SUB equal
    vecs[2]  = '{4'b1000, 8'h05, 8'h03, 8'h00, 8'hFE, 0, 0, 0}; // SUB borrow
    vecs[3]  = '{4'b0000, 8'h3C, 8'hF0, 8'h00, 8'h30, 0, 0, 0}; // AND
    vecs[4]  = '{4'b0010, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1, 0}; // XOR self
    vecs[5]  = '{4'b0011, 8'h03, 8'h05, 8'h2A, 8'h2A, 0, 0, 1}; // BNE taken
    vecs[6]  = '{4'b0011, 8'h07, 8'h07, 8'h2A, 8'h00, 0, 1, 0}; // BNE not taken
    vecs[7]  = '{4'b0100, 8'h01, 8'h81, 8'h00, 8'h02, 0, 0, 0}; // LSL 1
    vecs[8]  = '{4'b0101, 8'h09, 8'h81, 8'h00, 8'h00, 0, 1, 0}; // LSR by 9
    vecs[9]  = '{4'b1001, 8'h03, 8'h80, 8'h00, 8'hF0, 0, 0, 0}; // ASR 3
    vecs[10] = '{4'b1001, 8'h0C, 8'h80, 8'h00, 8'hFF, 0, 0, 0}; // ASR by 12
    vecs[11] = '{4'b0110, 8'h5A, 8'h11, 8'h00, 8'h5A, 0, 0, 0}; // LW
    vecs[12] = '{4'b0111, 8'hA5, 8'h11, 8'h00, 8'hA5, 0, 0, 0}; // STR
    vecs[13] = '{4'b1100, 8'h01, 8'h01, 8'h01, 8'h00, 0, 1, 0}; // illegal
    vecs[14] = '{4'b0101, 8'h01, 8'h81, 8'h00, 8'h40, 0, 0, 0}; // LSR 1
    vecs[15] = '{4'b0001, 8'h01, 8'h7F, 8'h00, 8'h80, 0, 0, 0}; // ADD no carry
    vecs[16] = '{4'b0100, 8'h08, 8'h81, 8'h00, 8'h00, 0, 1, 0}; // LSL by WIDTH
    vecs[17] = '{4'b1001, 8'h0C, 8'h40, 8'h00, 8'h00, 0, 1, 0}; // ASR positive big

    rst_n = 1'b0; start = 1'b0; cmd = '0; in_a = '0; in_b = '0; in_c = '0;
    #1;
    chk_all0("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all0("idle");

    // Back-to-back single-cycle ops: start held high the whole table.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].c);
      tick();
      chk($sformatf("v%0d.done", i),  32'(done), 1);
      chk($sformatf("v%0d.rslt", i),  32'(rslt), 32'(vecs[i].r));
      chk($sformatf("v%0d.carry", i), 32'(carry), 32'(vecs[i].cy));
      chk($sformatf("v%0d.zero", i),  32'(zero), 32'(vecs[i].z));
      chk($sformatf("v%0d.br", i),    32'(branch_pc), 32'(vecs[i].br));
      chk($sformatf("v%0d.busy", i),  32'(busy), 0);
    end

    // Taken branch, then idle: branch_pc and done drop, result holds.
    drive(1'b1, 4'b0011, 8'h03, 8'h05, 8'h2A);
    tick();
    chk("bne.br", 32'(branch_pc), 1);
    drive(1'b0, 4'b0001, 8'h00, 8'h00, 8'h00);
    tick();
    chk("bne.br_drop", 32'(branch_pc), 0);
    chk("bne.done_drop", 32'(done), 0);
    chk("bne.hold", 32'(rslt), 32'h2A);
    tick();
    chk("bne.hold2", 32'(rslt), 32'h2A);

    // MULLO 0x13*0x11 with an ADD start held during busy, then MULHI issued
    // in the done cycle.
    drive(1'b1, 4'b1010, 8'h11, 8'h13, 8'h00);
    tick();
    drive(1'b1, 4'b0001, 8'h01, 8'h01, 8'h00);
    for (int j = 0; j < W; j++) begin
      chk("mlo.busy", 32'(busy), 1);
      chk("mlo.nodone", 32'(done), 0);
      chk("mlo.hold", 32'(rslt), 32'h2A);
      tick();
    end
    chk("mlo.done", 32'(done), 1);
    chk("mlo.busy_end", 32'(busy), 0);
    chk("mlo.rslt", 32'(rslt), 32'h43);
    chk("mlo.carry", 32'(carry), 1);
    chk("mlo.zero", 32'(zero), 0);
    drive(1'b1, 4'b1011, 8'h11, 8'h13, 8'h00);
    tick();
    chk("mhi.busy", 32'(busy), 1);
    chk("mhi.done_drop", 32'(done), 0);
    drive(1'b0, 4'b0001, 8'hFF, 8'hFF, 8'h00); // operand changes mid-multiply
    for (int j = 0; j < W - 1; j++) tick();
    chk("mhi.hold", 32'(rslt), 32'h43);
    tick();
    chk("mhi.done", 32'(done), 1);
    chk("mhi.rslt", 32'(rslt), 32'h01);
    chk("mhi.carry", 32'(carry), 0);
    tick();
    chk("mhi.done_drop2", 32'(done), 0);

    mul_run("mlo_small", 4'b1010, 8'h05, 8'h03, 8'h0F, 1'b0);
    mul_run("mlo_ff", 4'b1010, 8'hFF, 8'hFF, 8'h01, 1'b1);
    mul_run("mhi_ff", 4'b1011, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    mul_run("mlo_zero", 4'b1010, 8'h00, 8'h9C, 8'h00, 1'b0);
    chk("mlo_zero.z", 32'(zero), 1);

    // Reset at iteration 4 aborts the multiply.
    drive(1'b1, 4'b1010, 8'h11, 8'h13, 8'h00);
    tick();
    drive(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("rstmul.busy", 32'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all0("rstmul");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < W + 2; j++) begin
      tick();
      chk("rstmul.nodone", 32'(done), 0);
      chk("rstmul.nobusy", 32'(busy), 0);
    end
    drive(1'b1, 4'b0001, 8'h01, 8'h01, 8'h00);
    tick();
    chk("post.done", 32'(done), 1);
    chk("post.rslt", 32'(rslt), 32'h02);
    chk("post.carry", 32'(carry), 0);
    drive(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00);
    tick();
    chk("post.done_drop", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
